q_pack8: RTL and testbench

- Downstream stage of the 8-bit quantized add unit.
- Consumes the unit's 8-bit result stream (C_OUT qualified by its output enable) and packs bytes little-endian into 32-bit words.
- Buffers packed words in a small first-word-fall-through FIFO and presents them to the write-back path with a valid/ready handshake.
- Reports frame completion, and optionally the signed min/max of the results.

---
 rtl/q_pack8.sv | 170 +++++++++++++++++
 tb/tb_q_pack8.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/q_pack8.sv
// q_pack8: packs a signed byte stream little-endian into 32-bit words and buffers them in a FWFT FIFO.
// Optional signed min/max tracking of each frame is built when Q_PACK8_STATS_EN is defined.
module q_pack8 #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET_X,
  input  logic             START,
  input  logic [CNT_W-1:0] LEN,
  input  logic             IN_EN,
  input  logic [7:0]       IN_DATA,
  output logic             IN_READY,
  output logic             OUT_VALID,
  output logic [31:0]      OUT_DATA,
  output logic [3:0]       OUT_MASK,
  output logic             OUT_LAST,
  input  logic             OUT_READY,
  output logic             BUSY,
  output logic             DONE,
  output logic             OVERRUN,
  output logic [7:0]       MIN,
  output logic [7:0]       MAX
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, PACK, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] len_q, cnt_q;
  logic [23:0]      asm_q;
  logic [36:0]      mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      fifo_cnt;
  logic [AW+1:0]    committed;
  logic [36:0]      head;
  logic [31:0]      word_data;
  logic [3:0]       word_mask;
  logic [1:0]       lane;
  logic             done_q, ovr_q;
  logic             start_frame, accept, last_byte, push, pop, done_set;

  // Handshakes: a byte moves when IN_EN & IN_READY, a word moves when OUT_VALID & OUT_READY;
  // IN_READY and OUT_VALID depend only on registered state, never on IN_EN or OUT_READY.
  assign start_frame = (state_q == IDLE) && START && (LEN != '0);
  assign lane        = cnt_q[1:0];
  // One FIFO slot stays reserved for the word under assembly so the push never overflows.
  assign committed   = {1'b0, fifo_cnt} + (AW+2)'(state_q == PACK);
  assign IN_READY    = (state_q == PACK) && (committed <= (AW+2)'(DEPTH - 2));
  assign accept      = IN_EN && IN_READY;
  assign last_byte   = (cnt_q + CNT_W'(1)) == len_q;
  assign push        = accept && ((lane == 2'd3) || last_byte);
  assign word_data   = {8'h00, asm_q} | ({24'h000000, IN_DATA} << {lane, 3'b000});

  assign head      = mem[rd_ptr];
  assign OUT_VALID = (fifo_cnt != '0);
  assign pop       = OUT_VALID && OUT_READY;
  assign OUT_DATA  = OUT_VALID ? head[31:0]  : 32'h0;
  assign OUT_MASK  = OUT_VALID ? head[35:32] : 4'h0;
  assign OUT_LAST  = OUT_VALID && head[36];
  assign BUSY      = (state_q != IDLE);
  assign DONE      = done_q;
  assign OVERRUN   = ovr_q;

  always_comb begin
    word_mask = 4'b0001;
    unique case (lane)
      2'd0: word_mask = 4'b0001;
      2'd1: word_mask = 4'b0011;
      2'd2: word_mask = 4'b0111;
      2'd3: word_mask = 4'b1111;
      default: word_mask = 4'b0001;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET_X) begin
    if (RESET_X) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    done_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          if (LEN != '0) state_d  = PACK;
          else           done_set = 1'b1;
        end
      end
      PACK:  if (push && last_byte) state_d = DRAIN;
      DRAIN: begin
        if (pop && head[36]) begin
          state_d  = IDLE;
          done_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET_X) begin
    if (RESET_X) begin
      len_q  <= '0;
      cnt_q  <= '0;
      asm_q  <= '0;
      ovr_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= done_set;
      if (start_frame) begin
        len_q <= LEN;
        cnt_q <= '0;
        asm_q <= '0;
        ovr_q <= 1'b0;
      end else begin
        if (accept) begin
          cnt_q <= cnt_q + CNT_W'(1);
          asm_q <= push ? 24'h000000 : word_data[23:0];
        end
        if ((state_q == PACK) && IN_EN && !IN_READY) ovr_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET_X) begin
    if (RESET_X) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Storage needs no reset: the outputs are gated by OUT_VALID.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= {last_byte, word_mask, word_data};
  end

`ifdef Q_PACK8_STATS_EN
  logic [7:0] min_q, max_q;

  always_ff @(posedge CLK or posedge RESET_X) begin
    if (RESET_X) begin
      min_q <= 8'h7F;
      max_q <= 8'h80;
    end else if (start_frame) begin
      min_q <= 8'h7F;
      max_q <= 8'h80;
    end else if (accept) begin
      if ($signed(IN_DATA) < $signed(min_q)) min_q <= IN_DATA;
      if ($signed(IN_DATA) > $signed(max_q)) max_q <= IN_DATA;
    end
  end

  assign MIN = min_q;
  assign MAX = max_q;
`else
  assign MIN = 8'h00;
  assign MAX = 8'h00;
`endif

endmodule

// File: tb/tb_q_pack8.sv
// Bench for q_pack8: directed frames from the test plan plus randomized frames against a packing model.
module tb_q_pack8;
  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic             CLK = 1'b0;
  logic             RESET_X;
  logic             START;
  logic [CNT_W-1:0] LEN;
  logic             IN_EN;
  logic [7:0]       IN_DATA;
  logic             IN_READY;
  logic             OUT_VALID;
  logic [31:0]      OUT_DATA;
  logic [3:0]       OUT_MASK;
  logic             OUT_LAST;
  logic             OUT_READY;
  logic             BUSY;
  logic             DONE;
  logic             OVERRUN;
  logic [7:0]       MIN;
  logic [7:0]       MAX;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int start_cyc = 0;
  int busy_gap  = 0;

  logic [7:0]  src_q[$];
  logic [7:0]  model_q[$];
  logic [7:0]  acc_q[$];
  int          acc_cyc[$];
  logic [36:0] exp_q[$];
  logic [36:0] got_q[$];
  int          got_cyc[$];
  int          done_cyc[$];
  logic        hold_chk = 1'b0;
  logic [36:0] held;

  q_pack8 #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET_X(RESET_X), .START(START), .LEN(LEN),
    .IN_EN(IN_EN), .IN_DATA(IN_DATA), .IN_READY(IN_READY),
    .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA), .OUT_MASK(OUT_MASK), .OUT_LAST(OUT_LAST),
    .OUT_READY(OUT_READY), .BUSY(BUSY), .DONE(DONE), .OVERRUN(OVERRUN),
    .MIN(MIN), .MAX(MAX)
  );

  // clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Inputs are applied at the falling edge; outputs are observed 1 time unit later.
  task automatic tick();
    #1;
    if (hold_chk) begin
      total++;
      if (OUT_VALID !== 1'b1 || {OUT_LAST, OUT_MASK, OUT_DATA} !== held) begin
        bad++;
        $display("FAIL hold_stable cyc=%0d got v=%b w=%h want v=1 w=%h",
                 cyc, OUT_VALID, {OUT_LAST, OUT_MASK, OUT_DATA}, held);
      end
    end
    hold_chk = (OUT_VALID === 1'b1) && (OUT_READY === 1'b0);
    held     = {OUT_LAST, OUT_MASK, OUT_DATA};
    if (IN_EN && IN_READY) begin
      acc_q.push_back(IN_DATA);
      acc_cyc.push_back(cyc);
    end
    if (OUT_VALID && OUT_READY) begin
      got_q.push_back({OUT_LAST, OUT_MASK, OUT_DATA});
      got_cyc.push_back(cyc);
    end
    if (DONE === 1'b1) done_cyc.push_back(cyc);
    @(negedge CLK);
    cyc++;
  endtask

  task automatic clear_logs();
    acc_q.delete(); acc_cyc.delete(); got_q.delete(); got_cyc.delete(); done_cyc.delete();
  endtask

  // Reference packing: byte i lands in word i/4, lane i%4; last word carries LAST.
  function automatic void build_exp(input int len);
    logic [31:0] d;
    logic [3:0]  m;
    exp_q.delete();
    for (int i = 0; i < len; i += 4) begin
      d = '0;
      m = '0;
      for (int k = 0; k < 4; k++) begin
        if (i + k < len) begin
          d[8*k +: 8] = model_q[i+k];
          m[k] = 1'b1;
        end
      end
      exp_q.push_back({(i + 4 >= len), m, d});
    end
  endfunction

  function automatic logic [15:0] ref_minmax(input int len);
`ifdef Q_PACK8_STATS_EN
    int mn = 127;
    int mx = -128;
    int v;
    for (int i = 0; i < len; i++) begin
      v = $signed(model_q[i]);
      if (v < mn) mn = v;
      if (v > mx) mx = v;
    end
    return {8'(mn), 8'(mx)};
`else
    return 16'h0000;
`endif
  endfunction

  // Drives one frame of src_q; the byte source only asserts IN_EN while IN_READY is high.
  task automatic run_frame(input int len, input int en_pct, input int rdy_pct, input bit spur);
    int budget = 0;
    busy_gap = 0;
    clear_logs();
    START = 1'b1; LEN = CNT_W'(len); IN_EN = 1'b0; OUT_READY = 1'b1;
    start_cyc = cyc;
    tick();
    START = 1'b0;
    while (done_cyc.size() == 0 && budget < 4000) begin
      if (BUSY !== 1'b1 && DONE !== 1'b1) busy_gap++;
      IN_EN     = (acc_q.size() < len) && IN_READY && ($urandom_range(99) < en_pct);
      IN_DATA   = (acc_q.size() < len) ? src_q[acc_q.size()] : 8'($urandom);
      OUT_READY = ($urandom_range(99) < rdy_pct);
      START     = spur && BUSY && ($urandom_range(15) == 0);
      LEN       = CNT_W'($urandom_range(1, 200));
      tick();
      budget++;
    end
    START = 1'b0; IN_EN = 1'b0; OUT_READY = 1'b1;
    if (done_cyc.size() == 0) begin
      total++; bad++;
      $display("FAIL frame_timeout len=%0d got done=0 want done=1", len);
    end
  endtask

  task automatic test_reset();
    logic [7:0] rmin, rmax;
`ifdef Q_PACK8_STATS_EN
    rmin = 8'h7F; rmax = 8'h80;
`else
    rmin = 8'h00; rmax = 8'h00;
`endif
    RESET_X = 1'b1; START = 1'b0; LEN = '0; IN_EN = 1'b0; IN_DATA = 8'h00; OUT_READY = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    total++;
    if ({IN_READY, OUT_VALID, OUT_LAST, BUSY, DONE, OVERRUN} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=000000", {IN_READY, OUT_VALID, OUT_LAST, BUSY, DONE, OVERRUN});
    end
    total++;
    if (OUT_DATA !== 32'h0 || OUT_MASK !== 4'h0) begin
      bad++;
      $display("FAIL reset_data got=%h/%h want=0/0", OUT_DATA, OUT_MASK);
    end
    total++;
    if (MIN !== rmin || MAX !== rmax) begin
      bad++;
      $display("FAIL reset_stats got=%h/%h want=%h/%h", MIN, MAX, rmin, rmax);
    end
    @(negedge CLK);
    RESET_X = 1'b0;
    hold_chk = 1'b0;
    tick();
    total++;
    if (IN_READY !== 1'b0 || BUSY !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset got rdy=%b busy=%b want 0/0", IN_READY, BUSY);
    end
  endtask

  task automatic test_len8();
    src_q.delete();
    for (int i = 1; i <= 8; i++) src_q.push_back(8'(i));
    run_frame(8, 100, 100, 1'b0);
    total++;
    if (got_q.size() != 2) begin
      bad++; $display("FAIL len8_count got=%0d want=2", got_q.size());
    end else begin
      total++;
      if (got_q[0] !== {1'b0, 4'hF, 32'h04030201}) begin
        bad++; $display("FAIL len8_word0 got=%h want=%h", got_q[0], {1'b0, 4'hF, 32'h04030201});
      end
      total++;
      if (got_q[1] !== {1'b1, 4'hF, 32'h08070605}) begin
        bad++; $display("FAIL len8_word1 got=%h want=%h", got_q[1], {1'b1, 4'hF, 32'h08070605});
      end
      total++;
      if (acc_cyc.size() == 8 && got_cyc[0] - acc_cyc[3] != 1) begin
        bad++; $display("FAIL len8_latency got=%0d want=1", got_cyc[0] - acc_cyc[3]);
      end
      total++;
      if (done_cyc.size() != 1 || done_cyc[0] != got_cyc[1] + 1) begin
        bad++; $display("FAIL len8_done_cycle got=%0d want=%0d",
                        (done_cyc.size() > 0) ? done_cyc[0] : -1, got_cyc[1] + 1);
      end
    end
    total++;
    if (busy_gap != 0) begin
      bad++; $display("FAIL len8_busy got_low_cycles=%0d want=0", busy_gap);
    end
    total++;
    if (BUSY !== 1'b0 || DONE !== 1'b0) begin
      bad++; $display("FAIL len8_after_done got busy=%b done=%b want 0/0", BUSY, DONE);
    end
  endtask

  task automatic test_len6();
    src_q.delete();
    for (int i = 0; i < 6; i++) src_q.push_back(8'h10 + 8'(i));
    run_frame(6, 100, 100, 1'b0);
    total++;
    if (got_q.size() != 2) begin
      bad++; $display("FAIL len6_count got=%0d want=2", got_q.size());
    end else begin
      total++;
      if (got_q[0] !== {1'b0, 4'hF, 32'h13121110}) begin
        bad++; $display("FAIL len6_word0 got=%h want=%h", got_q[0], {1'b0, 4'hF, 32'h13121110});
      end
      total++;
      if (got_q[1] !== {1'b1, 4'b0011, 32'h00001514}) begin
        bad++; $display("FAIL len6_word1 got=%h want=%h", got_q[1], {1'b1, 4'b0011, 32'h00001514});
      end
    end
  endtask

  task automatic test_len0();
    src_q.delete();
    run_frame(0, 100, 100, 1'b0);
    total++;
    if (done_cyc.size() != 1 || done_cyc[0] != start_cyc + 1) begin
      bad++; $display("FAIL len0_done got=%0d want=%0d",
                      (done_cyc.size() > 0) ? done_cyc[0] : -1, start_cyc + 1);
    end
    for (int k = 0; k < 4; k++) tick();
    total++;
    if (got_q.size() != 0 || BUSY !== 1'b0) begin
      bad++; $display("FAIL len0_no_word got words=%0d busy=%b want 0/0", got_q.size(), BUSY);
    end
  endtask

  task automatic test_stats();
    logic [15:0] want;
    src_q.delete();
    src_q.push_back(8'h05); src_q.push_back(8'hF0); src_q.push_back(8'h7F); src_q.push_back(8'h80);
    model_q = src_q;
`ifdef Q_PACK8_STATS_EN
    want = {8'h80, 8'h7F};
`else
    want = 16'h0000;
`endif
    run_frame(4, 100, 100, 1'b0);
    total++;
    if ({MIN, MAX} !== want || ref_minmax(4) !== want) begin
      bad++; $display("FAIL stats_value got=%h want=%h", {MIN, MAX}, want);
    end
    tick(); tick();
    total++;
    if ({MIN, MAX} !== want) begin
      bad++; $display("FAIL stats_hold got=%h want=%h", {MIN, MAX}, want);
    end
  endtask

  task automatic test_stall();
    int budget = 0;
    clear_logs();
    src_q.delete();
    for (int i = 0; i < 64; i++) src_q.push_back(8'(i * 7 + 3));
    START = 1'b1; LEN = CNT_W'(64); IN_EN = 1'b0; OUT_READY = 1'b0;
    tick();
    START = 1'b0;
    for (int k = 0; k < 40; k++) begin
      IN_EN   = IN_READY;
      IN_DATA = src_q[acc_q.size()];
      tick();
    end
    total++;
    if (acc_q.size() != 24 || IN_READY !== 1'b0) begin
      bad++; $display("FAIL stall_ready_drop got bytes=%0d rdy=%b want 24/0", acc_q.size(), IN_READY);
    end
    OUT_READY = 1'b1;
    while (done_cyc.size() == 0 && budget < 2000) begin
      IN_EN   = IN_READY && (acc_q.size() < 64);
      IN_DATA = (acc_q.size() < 64) ? src_q[acc_q.size()] : 8'h00;
      tick();
      budget++;
    end
    IN_EN = 1'b0;
    model_q = src_q;
    build_exp(64);
    total++;
    if (got_q.size() != exp_q.size() || done_cyc.size() != 1) begin
      bad++; $display("FAIL stall_count got=%0d done=%0d want=%0d done=1", got_q.size(), done_cyc.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL stall_word[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
      end
    end
    total++;
    if (OVERRUN !== 1'b0) begin
      bad++; $display("FAIL stall_overrun got=%b want=0", OVERRUN);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] pres_q[$];
    int budget = 0;
    clear_logs();
    START = 1'b1; LEN = CNT_W'(64); IN_EN = 1'b0; OUT_READY = 1'b0;
    tick();
    START = 1'b0;
    IN_EN = 1'b1;
    // cycles 0..39 stall the output; cycle 40 releases it and is still dropped
    for (int k = 0; k < 40; k++) begin
      IN_DATA = 8'($urandom);
      pres_q.push_back(IN_DATA);
      tick();
    end
    total++;
    if (acc_q.size() != 24) begin
      bad++; $display("FAIL ovr_accepted_before_stall got=%0d want=24", acc_q.size());
    end
    OUT_READY = 1'b1;
    while (done_cyc.size() == 0 && budget < 2000) begin
      IN_DATA = 8'($urandom);
      pres_q.push_back(IN_DATA);
      tick();
      budget++;
    end
    IN_EN = 1'b0;
    model_q.delete();
    for (int i = 0; i < 24; i++) model_q.push_back(pres_q[i]);
    for (int i = 41; i < 81 && i < pres_q.size(); i++) model_q.push_back(pres_q[i]);
    build_exp(64);
    total++;
    if (got_q.size() != exp_q.size() || model_q.size() != 64) begin
      bad++; $display("FAIL ovr_count got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL ovr_word[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
      end
    end
    total++;
    if (OVERRUN !== 1'b1) begin
      bad++; $display("FAIL ovr_flag got=%b want=1", OVERRUN);
    end
  endtask

  task automatic test_reset_drain();
    int budget = 0;
    clear_logs();
    src_q.delete();
    for (int i = 0; i < 12; i++) src_q.push_back(8'($urandom));
    START = 1'b1; LEN = CNT_W'(12); IN_EN = 1'b0; OUT_READY = 1'b0;
    tick();
    START = 1'b0;
    while (acc_q.size() < 12 && budget < 100) begin
      IN_EN   = IN_READY;
      IN_DATA = src_q[acc_q.size()];
      tick();
      budget++;
    end
    IN_EN = 1'b0;
    tick(); tick();
    total++;
    if (OUT_VALID !== 1'b1 || BUSY !== 1'b1) begin
      bad++; $display("FAIL rstd_pre got v=%b busy=%b want 1/1", OUT_VALID, BUSY);
    end
    RESET_X = 1'b1;
    #1;
    total++;
    if (OUT_VALID !== 1'b0 || BUSY !== 1'b0) begin
      bad++; $display("FAIL rstd_async got v=%b busy=%b want 0/0", OUT_VALID, BUSY);
    end
    @(negedge CLK);
    cyc++;
    RESET_X = 1'b0;
    hold_chk = 1'b0;
    clear_logs();
    OUT_READY = 1'b1; IN_EN = 1'b1; IN_DATA = 8'h55;
    for (int k = 0; k < 5; k++) tick();
    IN_EN = 1'b0;
    total++;
    if (done_cyc.size() != 0 || got_q.size() != 0 || OVERRUN !== 1'b0) begin
      bad++; $display("FAIL rstd_quiet got done=%0d words=%0d ovr=%b want 0/0/0", done_cyc.size(), got_q.size(), OVERRUN);
    end
    src_q.delete();
    src_q.push_back(8'hAA); src_q.push_back(8'hBB); src_q.push_back(8'hCC); src_q.push_back(8'hDD);
    run_frame(4, 100, 100, 1'b0);
    total++;
    if (got_q.size() != 1 || got_q[0] !== {1'b1, 4'hF, 32'hDDCCBBAA}) begin
      bad++; $display("FAIL rstd_next_frame got n=%0d w=%h want n=1 w=%h", got_q.size(),
                      (got_q.size() > 0) ? got_q[0] : 37'h0, {1'b1, 4'hF, 32'hDDCCBBAA});
    end
  endtask

  task automatic test_random();
    int len;
    for (int f = 0; f < 5; f++) begin
      len = $urandom_range(1, 40);
      src_q.delete();
      for (int i = 0; i < len; i++) src_q.push_back(8'($urandom));
      run_frame(len, 70, 60, 1'b1);
      model_q = src_q;
      build_exp(len);
      total++;
      if (got_q.size() != exp_q.size()) begin
        bad++; $display("FAIL rand%0d_count got=%0d want=%0d", f, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        total++;
        if (got_q[i] !== exp_q[i]) begin
          bad++; $display("FAIL rand%0d_word[%0d] got=%h want=%h", f, i, got_q[i], exp_q[i]);
        end
      end
      total++;
      if ({MIN, MAX} !== ref_minmax(len) || OVERRUN !== 1'b0) begin
        bad++; $display("FAIL rand%0d_stats got=%h ovr=%b want=%h ovr=0", f, {MIN, MAX}, OVERRUN, ref_minmax(len));
      end
    end
  endtask

  initial begin
    test_reset();
    test_len8();
    test_len6();
    test_len0();
    test_stats();
    test_stall();
    test_overrun();
    test_reset_drain();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
